// File: rtl/mix_mem_pkg.sv
// Shared constants and types for the MIX core memory arbiter.
package mix_mem_pkg;

  localparam int AW        = 12;
  localparam int DW        = 31;
  localparam int MEM_DEPTH = 4096;

  localparam int REQ_CPU = 0;
  localparam int REQ_MOV = 1;
  localparam int REQ_IN  = 2;
  localparam int REQ_OUT = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOCKED,
    FORCE_RELEASE
  } lock_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter.
//
// Handshake: req[i] is a level request that the requester holds, with
// addr/we/wdata stable, until gnt[i] is seen. gnt[i] high in a cycle means
// the access is performed in that same cycle. For a read (we[i]=0),
// rvalid[i] pulses exactly one cycle after the grant with rdata valid.
// Writes complete on the grant cycle and never produce rvalid.
interface mem_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = mix_mem_pkg::AW,
  parameter int DW    = mix_mem_pkg::DW
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    lock;
  logic [N_REQ-1:0]    we;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rvalid;
  logic [DW-1:0]       rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_arbiter_prio_pick.sv
// Combinational lowest-index-first picker: isolates the lowest set bit.
module prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] mask,
  output logic [N-1:0] onehot,
  output logic         any
);

  // Two's complement trick keeps only the lowest set bit of the mask.
  assign onehot = mask & (~mask + N'(1));
  assign any    = |mask;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port MIX core memory arbiter with aging and bounded lock bursts.
module mem_arbiter
  import mix_mem_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int AW       = mix_mem_pkg::AW,
  parameter int DW       = mix_mem_pkg::DW,
  parameter int MAX_WAIT = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      bus,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic [N_REQ-1:0]  urgent,
  output lock_state_t       lock_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = 8;

  lock_state_t      state, state_nxt;
  logic [IW-1:0]    owner, owner_nxt;
  logic [CW-1:0]    lock_cnt, lock_cnt_nxt;
  logic [7:0]       age [N_REQ];
  logic [N_REQ-1:0] rvalid_q;

  logic [N_REQ-1:0] urgent_v;
  logic [N_REQ-1:0] owner_bit;
  logic [N_REQ-1:0] excl;
  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] urg_mask;
  logic [N_REQ-1:0] urg_pick;
  logic [N_REQ-1:0] plain_pick;
  logic             urg_any;
  logic             plain_any;
  logic             lock_active;
  logic             preempt;
  logic [N_REQ-1:0] gnt_v;
  logic [IW-1:0]    win_idx;

  // Urgency flags from the age counters; held low throughout reset.
  always_comb begin
    urgent_v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      urgent_v[i] = (age[i] == 8'(MAX_WAIT)) && !reset;
    end
  end

  // Lock ownership qualification and the candidate mask for this cycle.
  always_comb begin
    owner_bit        = '0;
    owner_bit[owner] = 1'b1;
    lock_active      = (state == LOCKED) && bus.req[owner];
    preempt          = lock_active && (lock_cnt >= CW'(2)) &&
                       (|(urgent_v & bus.req & ~owner_bit));
    // After a burst hits its length limit the owner sits out one cycle,
    // unless nobody else wants the memory.
    excl = (state == FORCE_RELEASE) ? owner_bit : '0;
    cand = bus.req & ~excl;
    if (cand == '0) cand = bus.req;
  end

  assign urg_mask = cand & urgent_v;

  prio_pick #(.N(N_REQ)) u_pick_urgent (
    .mask   (urg_mask),
    .onehot (urg_pick),
    .any    (urg_any)
  );

  prio_pick #(.N(N_REQ)) u_pick_plain (
    .mask   (cand),
    .onehot (plain_pick),
    .any    (plain_any)
  );

  // Grant selection: lock owner, then urgent, then plain priority.
  always_comb begin
    gnt_v = '0;
    if (reset) begin
      gnt_v = '0;
    end else if (lock_active && !preempt) begin
      gnt_v = owner_bit;
    end else if (urg_any) begin
      gnt_v = urg_pick;
    end else if (plain_any) begin
      gnt_v = plain_pick;
    end
  end

  // Memory port mux driven by the winner; idle port presents zeros.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_v[i]) begin
        mem_addr  = bus.addr[i*AW +: AW];
        mem_we    = bus.we[i];
        mem_wdata = bus.wdata[i*DW +: DW];
        win_idx   = IW'(i);
      end
    end
  end

  // Lock FSM next state: continue, hit the length limit, or start a burst.
  always_comb begin
    state_nxt    = IDLE;
    owner_nxt    = owner;
    lock_cnt_nxt = '0;
    if (lock_active && !preempt) begin
      if (bus.lock[owner]) begin
        if (lock_cnt >= CW'(LOCK_MAX - 1)) begin
          state_nxt = FORCE_RELEASE;
        end else begin
          state_nxt    = LOCKED;
          lock_cnt_nxt = lock_cnt + CW'(1);
        end
      end
    end else if ((|(gnt_v & bus.lock)) &&
                 !((state == FORCE_RELEASE) && (gnt_v == owner_bit))) begin
      state_nxt    = LOCKED;
      owner_nxt    = win_idx;
      lock_cnt_nxt = CW'(1);
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Per-requester age counters, saturating at the urgency threshold.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (reset || !bus.req[i] || gnt_v[i]) begin
        age[i] <= '0;
      end else if (age[i] != 8'(MAX_WAIT)) begin
        age[i] <= age[i] + 8'd1;
      end
    end
  end

  // Read-response pipeline matching the one-cycle array latency.
  always_ff @(posedge clk) begin
    if (reset) rvalid_q <= '0;
    else       rvalid_q <= gnt_v & ~bus.we;
  end

  assign bus.gnt    = gnt_v;
  assign bus.rvalid = rvalid_q & {N_REQ{~reset}};
  assign bus.rdata  = mem_rdata;
  assign urgent     = urgent_v;
  assign lock_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  import mix_mem_pkg::*;

  localparam int NR = 4;

  logic              clk;
  logic              reset;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic [NR-1:0]     urgent;
  lock_state_t       lock_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  mem_arbiter_if #(.N_REQ(NR)) bus ();

  mem_arbiter #(.N_REQ(NR), .MAX_WAIT(8), .LOCK_MAX(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .urgent     (urgent),
    .lock_state (lock_state)
  );

  // Clock and memory array model (synchronous read, 1-cycle latency).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [MEM_DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_read(input string tag, input logic [NR-1:0] exp_rv);
    logic [DW-1:0] d;
    check_eq({tag, "_rvalid"}, 64'(bus.rvalid), 64'(exp_rv));
    check_eq({tag, "_q"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      check_eq({tag, "_rdata"}, 64'(bus.rdata), 64'(d));
    end
  endtask

  // Driver tasks.
  task automatic clear_all();
    bus.req   = '0;
    bus.lock  = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic drive(input int i, input bit l, input bit w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i]            = 1'b1;
    bus.lock[i]           = l;
    bus.we[i]             = w;
    bus.addr[i*AW +: AW]  = a;
    bus.wdata[i*DW +: DW] = d;
  endtask

  task automatic drop(input int i);
    bus.req[i]  = 1'b0;
    bus.lock[i] = 1'b0;
    bus.we[i]   = 1'b0;
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    clear_all();
    cyc_end();
    cyc_end();
  endtask

  initial begin
    reset = 1'b1;
    clear_all();
    drive(REQ_CPU, 1'b0, 1'b0, 12'd5, '0);
    cyc_end();
    cyc_end();

    // Reset state, with a request pending that must not be granted.
    sample();
    check_eq("rst_gnt", 64'(bus.gnt), 64'd0);
    check_eq("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check_eq("rst_urgent", 64'(urgent), 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_state", 64'(lock_state), 64'(IDLE));
    cyc_end();
    reset = 1'b0;
    clear_all();

    // Preload address 100 through the arbiter.
    drive(REQ_CPU, 1'b0, 1'b1, 12'd100, 31'h12345);
    sample();
    check_eq("pre_gnt", 64'(bus.gnt), 64'b0001);
    check_eq("pre_mem_we", 64'(mem_we), 64'd1);
    check_eq("pre_mem_addr", 64'(mem_addr), 64'd100);
    check_eq("pre_mem_wdata", 64'(mem_wdata), 64'h12345);
    cyc_end();
    clear_all();
    sample();
    check_eq("pre_no_rvalid", 64'(bus.rvalid), 64'd0);
    cyc_end();

    // Test 1: CPU read of address 100.
    drive(REQ_CPU, 1'b0, 1'b0, 12'd100, '0);
    sample();
    check_eq("t1_gnt", 64'(bus.gnt), 64'b0001);
    check_eq("t1_mem_we", 64'(mem_we), 64'd0);
    check_eq("t1_mem_addr", 64'(mem_addr), 64'd100);
    exp_q.push_back(31'h12345);
    cyc_end();
    clear_all();
    sample();
    check_read("t1", 4'b0001);
    idle();

    // Test 2: OUT starved by CPU becomes urgent after 8 denials.
    drive(REQ_CPU, 1'b0, 1'b0, 12'd1, '0);
    drive(REQ_OUT, 1'b0, 1'b0, 12'd7, '0);
    for (int c = 0; c < 8; c++) begin
      sample();
      check_eq($sformatf("t2_gnt_c%0d", c), 64'(bus.gnt), 64'b0001);
      check_eq($sformatf("t2_urg_c%0d", c), 64'(urgent), 64'd0);
      cyc_end();
    end
    sample();
    check_eq("t2_urg_c8", 64'(urgent), 64'b1000);
    check_eq("t2_gnt_c8", 64'(bus.gnt), 64'b1000);
    cyc_end();
    drop(REQ_OUT);
    sample();
    check_eq("t2_gnt_c9", 64'(bus.gnt), 64'b0001);
    check_eq("t2_rvalid_c9", 64'(bus.rvalid), 64'b1000);
    idle();

    // Test 3a: MOV lock burst of 16, forced release to CPU, then regrant.
    drive(REQ_MOV, 1'b1, 1'b0, 12'd10, '0);
    for (int c = 0; c < 16; c++) begin
      if (c == 15) drive(REQ_CPU, 1'b0, 1'b0, 12'd2, '0);
      sample();
      check_eq($sformatf("t3_gnt_c%0d", c), 64'(bus.gnt), 64'b0010);
      check_eq($sformatf("t3_st_c%0d", c), 64'(lock_state),
               (c == 0) ? 64'(IDLE) : 64'(LOCKED));
      cyc_end();
    end
    sample();
    check_eq("t3_st_c16", 64'(lock_state), 64'(FORCE_RELEASE));
    check_eq("t3_gnt_c16", 64'(bus.gnt), 64'b0001);
    cyc_end();
    drop(REQ_CPU);
    // MOV alone: new 16-cycle burst, then a lock-free grant when nobody else asks.
    for (int c = 17; c < 36; c++) begin
      sample();
      check_eq($sformatf("t3_gnt_c%0d", c), 64'(bus.gnt), 64'b0010);
      if (c == 17 || c == 34)
        check_eq($sformatf("t3_st_c%0d", c), 64'(lock_state), 64'(IDLE));
      if (c == 18 || c == 32 || c == 35)
        check_eq($sformatf("t3_st_c%0d", c), 64'(lock_state), 64'(LOCKED));
      if (c == 33)
        check_eq($sformatf("t3_st_c%0d", c), 64'(lock_state), 64'(FORCE_RELEASE));
      cyc_end();
    end
    idle();

    // Test 3b: urgent CPU preempts a running MOV lock.
    drive(REQ_MOV, 1'b1, 1'b0, 12'd11, '0);
    sample();
    check_eq("t3b_gnt_c0", 64'(bus.gnt), 64'b0010);
    cyc_end();
    drive(REQ_CPU, 1'b0, 1'b0, 12'd3, '0);
    for (int c = 1; c < 9; c++) begin
      sample();
      check_eq($sformatf("t3b_gnt_c%0d", c), 64'(bus.gnt), 64'b0010);
      cyc_end();
    end
    sample();
    check_eq("t3b_urg_c9", 64'(urgent), 64'b0001);
    check_eq("t3b_gnt_c9", 64'(bus.gnt), 64'b0001);
    cyc_end();
    drop(REQ_CPU);
    sample();
    check_eq("t3b_st_c10", 64'(lock_state), 64'(IDLE));
    check_eq("t3b_gnt_c10", 64'(bus.gnt), 64'b0010);
    idle();

    // Test 4: write top address then read it back.
    drive(REQ_CPU, 1'b0, 1'b1, 12'd4095, 31'h7FFFFFFF);
    sample();
    check_eq("t4_we_c1", 64'(mem_we), 64'd1);
    check_eq("t4_addr_c1", 64'(mem_addr), 64'd4095);
    check_eq("t4_wdata_c1", 64'(mem_wdata), 64'h7FFFFFFF);
    cyc_end();
    drive(REQ_CPU, 1'b0, 1'b0, 12'd4095, '0);
    sample();
    check_eq("t4_we_c2", 64'(mem_we), 64'd0);
    check_eq("t4_gnt_c2", 64'(bus.gnt), 64'b0001);
    check_eq("t4_rvalid_c2", 64'(bus.rvalid), 64'd0);
    exp_q.push_back(31'h7FFFFFFF);
    cyc_end();
    clear_all();
    sample();
    check_read("t4_c3", 4'b0001);
    idle();

    // Test 5: IN and OUT reach urgency together.
    drive(REQ_CPU, 1'b0, 1'b0, 12'd4, '0);
    drive(REQ_IN,  1'b0, 1'b1, 12'd20, 31'h55);
    drive(REQ_OUT, 1'b0, 1'b0, 12'd21, '0);
    for (int c = 0; c < 8; c++) begin
      sample();
      check_eq($sformatf("t5_gnt_c%0d", c), 64'(bus.gnt), 64'b0001);
      cyc_end();
    end
    sample();
    check_eq("t5_urg_c8", 64'(urgent), 64'b1100);
    check_eq("t5_gnt_c8", 64'(bus.gnt), 64'b0100);
    cyc_end();
    drop(REQ_IN);
    sample();
    check_eq("t5_urg_c9", 64'(urgent), 64'b1000);
    check_eq("t5_gnt_c9", 64'(bus.gnt), 64'b1000);
    cyc_end();
    drop(REQ_OUT);
    sample();
    check_eq("t5_urg_c10", 64'(urgent), 64'd0);
    check_eq("t5_gnt_c10", 64'(bus.gnt), 64'b0001);
    idle();

    // Test 6: reset right after a read grant suppresses the response.
    drive(REQ_CPU, 1'b0, 1'b0, 12'd100, '0);
    sample();
    check_eq("t6_gnt_c0", 64'(bus.gnt), 64'b0001);
    cyc_end();
    reset = 1'b1;
    sample();
    check_eq("t6_rst_gnt", 64'(bus.gnt), 64'd0);
    check_eq("t6_rst_rvalid", 64'(bus.rvalid), 64'd0);
    check_eq("t6_rst_urgent", 64'(urgent), 64'd0);
    cyc_end();
    reset = 1'b0;
    sample();
    check_eq("t6_post_rvalid", 64'(bus.rvalid), 64'd0);
    check_eq("t6_post_gnt", 64'(bus.gnt), 64'b0001);
    check_eq("t6_post_urgent", 64'(urgent), 64'd0);
    exp_q.push_back(31'h12345);
    cyc_end();
    clear_all();
    sample();
    check_read("t6_post", 4'b0001);
    cyc_end();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single port of the 4096x31 MIX core memory and arbitrates it among four requesters.
- Requester 0 is the CPU (instruction fetch, operand load, store). Requester 1 is the MOV engine, requester 2 is IN device store, requester 3 is OUT device load.
- Replaces the ad-hoc address/write-enable priority muxing around the memory array.
- Adds starvation protection (aging) and bounded lock bursts, so device traffic cannot be blocked indefinitely by back-to-back CPU accesses.

Parameters:
- N_REQ, 4, number of requesters; index 0 has the highest base priority.
- AW, 12, memory address width.
- DW, 31, memory word width (sign + 5 six-bit bytes).
- MAX_WAIT, 8, consecutive denied cycles before a requester becomes urgent (range 1..255).
- LOCK_MAX, 16, maximum consecutive granted cycles under lock (range 2..255).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  N_REQ  access request per requester, level, held until granted
- lock  in  N_REQ  requester asks to keep the grant next cycle (read-modify / MOV bursts)
- we  in  N_REQ  write enable per requester, qualified by req
- addr  in  N_REQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
- wdata  in  N_REQ*DW  packed write data; requester i uses bits [i*DW +: DW]
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as the access
- rvalid  out  N_REQ  one-hot; rdata is valid for this requester
- rdata  out  DW  read data, shared by all requesters
- mem_addr  out  AW  to memory array
- mem_we  out  1  to memory array
- mem_wdata  out  DW  to memory array
- mem_rdata  in  DW  from memory array, synchronous read, 1-cycle latency
- urgent  out  N_REQ  debug: aging threshold reached

Behaviour:
- Reset values: gnt=0, rvalid=0, urgent=0, all age counters=0, lock owner=none, lock counter=0, mem_we=0, mem_addr=0.
- gnt is forced to 0 for as long as reset is high.
- Grant selection, in order of precedence:
  1. If a lock owner exists and its req=1, it is granted.
  2. Otherwise the lowest-index requester with urgent=1 and req=1 is granted.
  3. Otherwise the lowest-index requester with req=1 is granted.
  4. If no req is active, gnt=0 and mem_we=0.
- Access path: the granted requester's addr, we and wdata are driven to the mem_* ports in the same cycle. mem_we is asserted only when a grant exists and the winner's we=1.
- Read latency: when a granted access is a read (we=0), rvalid[i] pulses exactly one cycle after the grant. rdata passes mem_rdata through; it is don't-care when rvalid=0.
- Writes produce no rvalid. A write to address A followed next cycle by a read of A returns the new data (array write-first is not required; the ordering is inherent).
- Aging, per requester i:
  - age[i] increments when req[i]=1 and gnt[i]=0, saturating at MAX_WAIT.
  - age[i] clears to 0 on gnt[i]=1 or when req[i]=0.
  - urgent[i] = (age[i]==MAX_WAIT).
- Lock:
  - When gnt[i]=1 and lock[i]=1, i becomes owner next cycle and the lock counter increments.
  - Ownership ends when the owner's lock=0, its req=0, or the lock counter reaches LOCK_MAX-1.
  - On the counter condition, the owner is excluded from the next cycle's arbitration, so at least one other pending requester gets a slot. If no one else requests, the owner is granted normally without lock.
- Urgent requesters preempt a lock once the lock has run 2 or more cycles. Ownership then drops and the counter clears.
- Simultaneous urgency: the lowest index wins; the others keep age saturated and win on later cycles.
- Reset mid-operation: a pending rvalid is suppressed. Requesters must reissue.
- Requester contract: a requester must not change addr/we/wdata while req=1 and gnt=0. Violations are not detected.

Decomposition:
- Shared package mix_mem_pkg: AW, DW, requester index constants (REQ_CPU=0, REQ_MOV=1, REQ_IN=2, REQ_OUT=3), memory depth 4096.
- One sub-module, prio_pick: a combinational lowest-index-first picker over an N_REQ mask. It is instantiated twice, once for the urgent mask and once for the plain mask.
- Age counters, lock FSM (IDLE/LOCKED/FORCE_RELEASE) and the rvalid pipeline register stay in mem_arbiter.

Test Plan:
1. req=0001 read addr 100 (memory holds 0x12345) -> gnt=0001 in the same cycle, mem_we=0; next cycle rvalid=0001, rdata=0x12345.
2. CPU requests every cycle, req[3] held from cycle 0 -> OUT denied cycles 0..7, urgent[3]=1 at cycle 8, gnt=1000 at cycle 8; CPU granted again at cycle 9.
3. MOV req+lock continuous, CPU req continuous, LOCK_MAX=16 -> MOV granted 16 consecutive cycles, CPU granted the 17th cycle, MOV regranted after.
4. CPU writes 0x7FFFFFFF to 4095, then reads 4095 -> mem_we=1 on cycle 1, rdata=0x7FFFFFFF with rvalid[0] on cycle 3; no address wrap fault.
5. IN and OUT both reach urgent in the same cycle -> IN (index 2) is granted first, OUT is granted the next cycle with urgent[3] still 1 until granted.
6. Read granted, reset asserted next cycle -> rvalid=0, gnt=0, urgent=0 during and after reset; the first post-reset request is granted normally.
